// File: rtl/keypad_encoder_fifo.sv
// Keypad front end: sync + debounce a one-hot key bank, encode to a digit, queue it in a FIFO.
// Latency: a press is pushed 2+DEBOUNCE edges after the key edge; the head shows on D one edge after the push.
// Backpressure: valid/ready on the FIFO head; a push into a full FIFO with no pop is dropped and flags ovf.

module kef_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_vld,
  input  logic [W-1:0]             push_dat,
  output logic                     push_rdy,
  output logic                     pop_vld,
  output logic [W-1:0]             pop_dat,
  input  logic                     pop_rdy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [AW:0]  rd_ptr_nxt;
  logic         full;
  logic         pop_fire;
  logic         push_fire;
  logic         head_vld;

  assign full       = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign pop_fire   = pop_vld && pop_rdy;
  assign push_rdy   = !full || pop_fire;
  assign push_fire  = push_vld && push_rdy;
  assign rd_ptr_nxt = pop_fire ? rd_ptr + PTR_ONE : rd_ptr;
  assign level      = wr_ptr - rd_ptr;

  // Head is judged against the pre-push write pointer, so a fresh entry never bypasses to D.
  assign head_vld = (wr_ptr != rd_ptr_nxt);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pop_vld <= 1'b0;
      pop_dat <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      rd_ptr  <= rd_ptr_nxt;
      pop_vld <= head_vld;
      pop_dat <= head_vld ? mem[rd_ptr_nxt[AW-1:0]] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem[wr_ptr[AW-1:0]] <= push_dat;
    end
  end

endmodule

// Keypad encoder top: synchroniser, press/release debounce FSM, digit FIFO, status flags.
// Latency: loadn is low the cycle after edge E(1+DEBOUNCE) counted from the key capture edge E0.
// Backpressure: consumer pops with ready; overflowing digits are dropped and latched in sticky ovf.

module keypad_encoder_fifo #(
  parameter int NKEYS    = 10,
  parameter int DW       = 4,
  parameter int DEBOUNCE = 4,
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     enbn,
  input  logic [NKEYS-1:0]         key,
  output logic [DW-1:0]            D,
  output logic                     valid,
  input  logic                     ready,
  output logic                     loadn,
  output logic                     pgt,
  output logic                     multi,
  output logic                     ovf,
  output logic [$clog2(DEPTH):0]   level
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  localparam logic [NKEYS-1:0] KEY_ONE = NKEYS'(1);
  localparam logic [7:0]       DEB_CNT = 8'(DEBOUNCE);
  localparam logic [7:0]       CNT_ONE = 8'd1;

  state_t           state;
  state_t           state_nxt;
  logic [NKEYS-1:0] key_s1;
  logic [NKEYS-1:0] key_s;
  logic [NKEYS-1:0] pat;
  logic [NKEYS-1:0] pat_nxt;
  logic [DW-1:0]    idx;
  logic [DW-1:0]    idx_nxt;
  logic [DW-1:0]    key_idx;
  logic [7:0]       cnt;
  logic [7:0]       cnt_nxt;
  logic [7:0]       cnt_inc;
  logic             any_key;
  logic             one_hot;
  logic             multi_nxt;
  logic             push_vld;
  logic             push_rdy;
  logic [DW-1:0]    push_dat;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      key_s1 <= '0;
      key_s  <= '0;
    end else begin
      key_s1 <= key;
      key_s  <= key_s1;
    end
  end

  assign any_key   = |key_s;
  assign multi_nxt = (key_s & (key_s - KEY_ONE)) != '0;
  assign one_hot   = any_key && !multi_nxt;
  assign cnt_inc   = cnt + CNT_ONE;

  always_comb begin
    key_idx = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if (key_s[i]) begin
        key_idx = DW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      pat   <= '0;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      pat   <= pat_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pat_nxt   = pat;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    if (enbn) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (one_hot) begin
            pat_nxt   = key_s;
            idx_nxt   = key_idx;
            cnt_nxt   = CNT_ONE;
            state_nxt = (DEBOUNCE == 1) ? ST_HELD : ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (key_s == pat) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == DEB_CNT) begin
              state_nxt = ST_HELD;
            end
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_HELD: begin
          // Extra or different keys while held are ignored; only all-released counts.
          if (!any_key) begin
            cnt_nxt   = CNT_ONE;
            state_nxt = (DEBOUNCE == 1) ? ST_IDLE : ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (any_key) begin
            state_nxt = ST_HELD;
          end else begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == DEB_CNT) begin
              state_nxt = ST_IDLE;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pgt      = (state == ST_HELD) || (state == ST_RELEASE);
    push_vld = 1'b0;
    push_dat = idx;
    if (!enbn) begin
      if (state == ST_IDLE && DEBOUNCE == 1 && one_hot) begin
        push_vld = 1'b1;
        push_dat = key_idx;
      end else if (state == ST_DEBOUNCE && key_s == pat && cnt_inc == DEB_CNT) begin
        push_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      loadn <= 1'b1;
      ovf   <= 1'b0;
      multi <= 1'b0;
    end else begin
      loadn <= !(push_vld && push_rdy);
      ovf   <= ovf || (push_vld && !push_rdy);
      multi <= multi_nxt;
    end
  end

  kef_fifo #(
    .W     (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .push_rdy (push_rdy),
    .pop_vld  (valid),
    .pop_dat  (D),
    .pop_rdy  (ready),
    .level    (level)
  );

endmodule

// File: doc/keypad_encoder_fifo.md
# keypad_encoder_fifo

Parametrised successor to the microwave keypad encoder. It synchronises and debounces a one-hot key bank, encodes each accepted press to a binary digit, and issues an active-low `loadn` strobe per accepted digit. Digits are buffered in a small FIFO with a valid/ready output, so the time-setting logic can drain entries at its own pace. It adds press/release debouncing, multi-key rejection and overflow reporting.

## Interface
- `NKEYS`, 10: number of key lines; `key[i]` encodes digit value i.
- `DW`, 4: digit width; requires 2^DW >= NKEYS.
- `DEBOUNCE`, 4: consecutive stable synchronised samples required for press and for release; range 1..255.
- `DEPTH`, 4: FIFO entries; power of 2, >= 2.
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `enbn`  in  1  active-low enable; high forces FSM to IDLE, no captures.
- `key`  in  NKEYS  raw key lines, asynchronous, active-high.
- `D`  out  DW  FIFO head digit; 0 when empty.
- `valid`  out  1  FIFO non-empty.
- `ready`  in  1  consumer pop; pop occurs when valid && ready.
- `loadn`  out  1  low for exactly one cycle per digit pushed.
- `pgt`  out  1  high while a press is accepted and not yet released (HELD, RELEASE).
- `multi`  out  1  registered; high in any cycle the synchronised key has >1 bit set.
- `ovf`  out  1  sticky; set when a debounced digit is dropped because FIFO full; cleared only by reset.
- `level`  out  clog2(DEPTH)+1  FIFO occupancy.

## Operation
- `key` passes through a 2-flop synchroniser; `s` denotes the synchroniser output. Only `s` feeds the FSM.
- FSM states: IDLE, DEBOUNCE, HELD, RELEASE.
- IDLE: if `enbn`=0 and `s` is one-hot, latch the pattern and its index, set cnt=1, go to DEBOUNCE. Zero or multi-bit `s` stays in IDLE.
- DEBOUNCE: if `s` equals the latched pattern, increment cnt. When the sample makes cnt reach DEBOUNCE, push the index and go to HELD. Any mismatch returns to IDLE with no push.
  - With DEBOUNCE=1, the push happens at the IDLE sample: IDLE goes directly to HELD.
- HELD: stays while `s` is nonzero, including a different or multi-key pattern, which is ignored. When `s`=0, set cnt=1 and go to RELEASE.
- RELEASE: if `s`=0, increment cnt; reaching DEBOUNCE goes to IDLE. Any nonzero `s` returns to HELD.
- Push: if not full, or full with a simultaneous pop, write the entry and pulse `loadn` low for the next cycle. If full without a pop, drop the digit, set `ovf`, and leave `loadn` high.
- FIFO: read/write pointers with an extra wrap bit. Full when the pointers differ only in the MSB; empty when they are equal.
- Simultaneous push and pop while empty: impossible, since valid=0. Simultaneous push and pop while non-empty: level is unchanged.
- No bypass: a digit pushed into an empty FIFO appears on `D` with `valid`=1 one cycle after `loadn` falls.
- `enbn`=1 in any state: next state is IDLE and any in-progress press is abandoned without a push. FIFO pops continue. A key still held when `enbn` returns low is treated as a fresh press.

## Timing
- Reset (async assert, sync-safe deassert via the same flops): FSM=IDLE, synchroniser=0, FIFO empty, D=0, valid=0, loadn=1, pgt=0, multi=0, ovf=0, level=0.
- Press latency: edge E0 captures key into sync stage 1, and E1 captures it into `s`. FSM samples at E2..E(1+DEBOUNCE). The push occurs at edge E(1+DEBOUNCE), so `loadn` is low during the cycle after that edge.
  - Default case: loadn is low after the 6th edge counting E0.
- `level` updates on the push edge. `valid` and `D` are registered outputs, valid one edge after the push.
- Pop: on the edge where valid && ready, the head advances. `D` shows the next entry, or 0, after that edge.
- `pgt` rises on the push edge and falls on the RELEASE→IDLE edge.
- Minimum press-to-press spacing at defaults: 4 press samples + 4 release samples + 1 IDLE sample.
- Reset asserted mid-press or mid-release: everything returns immediately to the reset values, and FIFO contents are lost.

## Test plan
- Single press: key=10'b10_0000_0000 held 10 cycles, then 0, with ready=0. Expect one loadn low pulse at E5, D=9, valid=1, level=1, pgt high until 4 zero samples pass, ovf=0.
- Bounce: key toggles 0x200/0x000 every 2 cycles for 12 cycles, then held 0x100 for 8 cycles. Expect no push during toggling, then exactly one push of D=8.
- Multi-key: key=0x006 held 10 cycles. Expect multi=1 from E1+1, no push, pgt=0. Then key=0x004 gives a push of 2.
- Overflow: 5 clean presses (1,2,3,4,5) with ready=0, DEPTH=4. Expect level=4 and ovf=1 with no loadn on the 5th. Then hold ready=1 and expect D sequence 1,2,3,4, then valid=0, D=0.
- Full + pop same cycle: FIFO full, ready=1 on the 5th press's push edge. Expect push accepted, loadn pulse, level stays 4, ovf=0.
- Enable/reset mid-operation: enbn=1 during DEBOUNCE gives no push. rstn low during HELD gives all outputs at reset values within the same cycle.
